// File: rtl/mult32x32_arbiter.sv
// rtl/mult32x32_arbiter.sv - two-requester arbiter for a shared 32x32 multiplier
// Optional round-robin tie-break: define MULT_ARB_ROUND_ROBIN_EN (default build is fixed priority, requester 0 first).
module mult32x32_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        done0,
    output logic        done1,
    output logic [63:0] result,
    output logic        arb_busy,
    output logic        m_start,
    output logic [31:0] m_a,
    output logic [31:0] m_b,
    input  logic        m_busy,
    input  logic [63:0] m_product
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] ma_q, ma_d;
    logic [31:0] mb_q, mb_d;
    logic [63:0] result_q, result_d;
    logic        grant;

`ifdef MULT_ARB_ROUND_ROBIN_EN
    logic        last_q, last_d;

    // On a tie the requester that was not served last wins.
    always_comb begin
        if (req0 && req1) begin
            grant = ~last_q;
        end else begin
            grant = ~req0;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == S_DONE) begin
            last_d = owner_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant = ~req0;
    end
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d = grant;
                    ma_d    = grant ? a1 : a0;
                    mb_d    = grant ? b1 : b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (m_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!m_busy) begin
                    result_d = m_product;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            ma_q     <= 32'd0;
            mb_q     <= 32'd0;
            result_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            result_q <= result_d;
        end
    end

    assign m_start  = (state_q == S_START);
    assign arb_busy = (state_q != S_IDLE);
    assign done0    = (state_q == S_DONE) && !owner_q;
    assign done1    = (state_q == S_DONE) &&  owner_q;
    assign m_a      = ma_q;
    assign m_b      = mb_q;
    assign result   = result_q;

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// tb/tb_mult32x32_arbiter.sv - self-checking bench for mult32x32_arbiter with a behavioural multiplier
module tb_mult32x32_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [31:0] a0, b0, a1, b1;
    logic        done0, done1;
    logic [63:0] result;
    logic        arb_busy;
    logic        m_start;
    logic [31:0] m_a, m_b;
    logic        m_busy;
    logic [63:0] m_product;

    int          checks = 0;
    int          errors = 0;
    int          busy_len = 4;
    int          model_last = 1;
    logic [63:0] last_res;

    mult32x32_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .result(result),
        .arb_busy(arb_busy), .m_start(m_start),
        .m_a(m_a), .m_b(m_b),
        .m_busy(m_busy), .m_product(m_product)
    );

    always #5 clk = ~clk;

    // Multiplier: busy for busy_len cycles after a start, product appears only as busy falls.
    int          mul_cnt;
    logic [63:0] mul_pending;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_cnt     <= 0;
            m_busy      <= 1'b0;
            m_product   <= 64'd0;
            mul_pending <= 64'd0;
        end else if (m_start) begin
            mul_cnt     <= busy_len;
            m_busy      <= 1'b1;
            m_product   <= 64'd0;
            mul_pending <= {32'd0, m_a} * {32'd0, m_b};
        end else if (mul_cnt > 1) begin
            mul_cnt <= mul_cnt - 1;
        end else if (m_busy) begin
            mul_cnt   <= 0;
            m_busy    <= 1'b0;
            m_product <= mul_pending;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic r0, input logic r1);
        if (r0 && r1) begin
`ifdef MULT_ARB_ROUND_ROBIN_EN
            return (model_last == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        return r0 ? 0 : 1;
    endfunction

    // hook: 0 none, 1 change a0 after grant, 2 raise req1 in WAIT_DONE, 3 drop req0 after grant
    task automatic wait_done(input int hook, output int who, output logic [63:0] res,
                             output logic [31:0] sa, output logic [31:0] sb, output int starts);
        int busy_seen;
        who = -1; res = 64'd0; sa = 32'd0; sb = 32'd0; starts = 0; busy_seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (m_start) begin
                starts++;
                sa = m_a;
                sb = m_b;
                if (hook == 1) a0 = 32'd1;
                if (hook == 3) req0 = 1'b0;
            end
            if (m_busy) begin
                busy_seen++;
                if (hook == 2 && busy_seen == 2) req1 = 1'b1;
            end
            if (done0 || done1) begin
                chk("both_done", {63'd0, done0 & done1}, 64'd0);
                who = done1 ? 1 : 0;
                res = result;
                break;
            end
        end
        if (who < 0) chk("timeout", 64'd1, 64'd0);
    endtask

    task automatic expect_op(input string tag, input int hook, input logic nr0, input logic nr1);
        int          w, who, starts;
        logic [31:0] ea, eb, sa, sb;
        logic [63:0] res;
        w  = pick(req0, req1);
        ea = (w == 1) ? a1 : a0;
        eb = (w == 1) ? b1 : b0;
        wait_done(hook, who, res, sa, sb, starts);
        chk({tag, "_who"}, 64'(who), 64'(w));
        chk({tag, "_result"}, res, {32'd0, ea} * {32'd0, eb});
        chk({tag, "_m_a"}, {32'd0, sa}, {32'd0, ea});
        chk({tag, "_m_b"}, {32'd0, sb}, {32'd0, eb});
        chk({tag, "_starts"}, 64'(starts), 64'd1);
        model_last = w;
        last_res   = res;
        req0 = nr0;
        req1 = nr1;
        @(negedge clk);
        chk({tag, "_pulse_end"}, {62'd0, done0, done1}, 64'd0);
        chk({tag, "_idle"}, {63'd0, arb_busy}, 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"}, {62'd0, done0, done1}, 64'd0);
        chk({tag, "_start_busy"}, {62'd0, m_start, arb_busy}, 64'd0);
        chk({tag, "_m_ab"}, {m_a, m_b}, 64'd0);
        chk({tag, "_result"}, result, 64'd0);
    endtask

    function automatic logic [31:0] rnd_op();
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) return 32'd0;
        if (k == 1) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    initial begin
        int w, bs;
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;
        model_last = 1;

        // tie from reset: requester 0 first, then round-robin or fixed priority
        a0 = 32'd2; b0 = 32'd2; a1 = 32'd7; b1 = 32'd6; busy_len = 3;
        req0 = 1'b1; req1 = 1'b1;
        expect_op("tie1", 0, 1'b1, 1'b1);
        chk("tie1_val", last_res, 64'd4);
        expect_op("tie2", 0, 1'b1, 1'b1);
        expect_op("tie3", 0, 1'b0, 1'b0);

        // single request, long busy
        a0 = 32'd3; b0 = 32'd5; busy_len = 8; req0 = 1'b1;
        expect_op("single0", 0, 1'b0, 1'b0);
        chk("single0_val", last_res, 64'd15);

        // maximal operands
        a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; busy_len = 2; req1 = 1'b1;
        expect_op("max1", 0, 1'b0, 1'b0);
        chk("max1_val", last_res, 64'hFFFF_FFFE_0000_0001);

        // req1 arrives mid-operation and waits for IDLE
        a0 = 32'd6; b0 = 32'd7; a1 = 32'd10; b1 = 32'd12; busy_len = 5; req0 = 1'b1;
        expect_op("late_a", 2, 1'b0, 1'b1);
        expect_op("late_b", 0, 1'b0, 1'b0);
        chk("late_b_val", last_res, 64'd120);

        // operand change after grant is ignored
        a0 = 32'd9; b0 = 32'd9; busy_len = 3; req0 = 1'b1;
        expect_op("latch", 1, 1'b0, 1'b0);
        chk("latch_val", last_res, 64'd81);

        // request dropped after grant still completes
        a0 = 32'd11; b0 = 32'd13; busy_len = 2; req0 = 1'b1;
        expect_op("drop", 3, 1'b0, 1'b0);

        // reset during WAIT_DONE
        a0 = 32'd5; b0 = 32'd5; busy_len = 8; req0 = 1'b1;
        bs = 0;
        for (int c = 0; c < 50 && bs < 2; c++) begin
            @(negedge clk);
            if (m_busy) bs++;
        end
        chk("rst_reach_wait", 64'(bs), 64'd2);
        reset = 1'b0; req0 = 1'b0;
        #1;
        chk_zero("rst_async");
        @(negedge clk);
        chk_zero("rst_hold");
        reset = 1'b1;
        model_last = 1;
        a1 = 32'd4; b1 = 32'd4; busy_len = 2; req1 = 1'b1;
        expect_op("post_rst", 0, 1'b0, 1'b0);
        chk("post_rst_val", last_res, 64'd16);

        // randomized requests and operands against the model
        for (int i = 0; i < 16; i++) begin
            bs = $urandom_range(1, 3);
            a0 = rnd_op(); b0 = rnd_op(); a1 = rnd_op(); b1 = rnd_op();
            busy_len = $urandom_range(1, 6);
            req0 = bs[0]; req1 = bs[1];
            if (req0 && req1) begin
                w = pick(1'b1, 1'b1);
                expect_op("rnd_tie", 0, (w == 1), (w == 0));
                expect_op("rnd_next", 0, 1'b0, 1'b0);
            end else begin
                expect_op("rnd_one", 0, 1'b0, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
